proc_hier_top: RTL and testbench
================================

Name: proc_hier_top

Overview:
- Single-cycle 16-bit processor core: PC, instruction decode, 8x16 register file, ALU, load/store to an external data memory, HALT.
- Fetches from an external combinational instruction memory.
- Exposes the architectural trace signals (register write, memory access, halt, cycle count) that the simulation bench logs every clock.
- Top of the processor hierarchy; instantiated directly by the processor bench.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  16  fetch address; equals PC.
- imem_rdata  in  16  instruction at imem_addr; combinational, same cycle.
- pc  out  16  current PC.
- inst  out  16  instruction currently executing; equals imem_rdata.
- reg_write  out  1  register file written at the next rising edge.
- write_reg  out  3  destination register.
- write_data  out  16  data being written.
- mem_read  out  1  load this cycle.
- mem_write  out  1  store this cycle.
- mem_addr  out  16  data address.
- mem_wdata  out  16  store data.
- mem_rdata  in  16  load data; combinational from mem_addr.
- halt  out  1  HALT executed; sticky.
- cycle_count  out  32  cycles since reset deassertion.
- icache_req, icache_hit, dcache_req, dcache_hit  out  1 each  tied to 0; no caches in this block.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC; all registers 0; halted flag 0; cycle_count 0.
  - All trace strobes (reg_write, mem_read, mem_write, halt) forced 0 while in reset.
- Execution:
  - One instruction per cycle, fully combinational.
  - State (PC, register file, halted flag) commits on the rising edge.
  - Default next PC = pc+2, 16-bit wrap (16'hFFFE -> 16'h0000).
- Opcode = inst[15:11]. Fields: Rs=[10:8], Rt=[7:5], Rd=[4:2]. imm5 = sign-extended [4:0]; imm8 = sign-extended [7:0]; imm11 = sign-extended [10:0].
- Instructions:
  - 00000 HALT: halt=1; PC frozen; no register or memory writes from then on.
  - 00001 NOP.
  - 01000 ADDI: R[Rt] = R[Rs] + imm5.
  - 10000 ST: Mem[R[Rs]+imm5] = R[Rt]; mem_write=1; mem_wdata=R[Rt].
  - 10001 LD: R[Rt] = Mem[R[Rs]+imm5]; mem_read=1.
  - 11000 LBI: R[Rs] = imm8.
  - 01100 BEQZ: if R[Rs]==0, next PC = pc+2+imm8; otherwise pc+2.
  - 00100 J: next PC = pc+2+imm11.
  - 11011 ALU, selected by inst[1:0]; result to R[Rd]:
    - 00: R[Rs]+R[Rt]
    - 01: R[Rt]-R[Rs]
    - 10: R[Rs]^R[Rt]
    - 11: R[Rs]&~R[Rt]
  - All other opcodes execute as NOP.
- Arithmetic: all 16-bit modulo; overflow is ignored.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - R0 is an ordinary register.
  - A read of the register being written in the same cycle returns the old value.
- Trace outputs:
  - reg_write, write_reg, write_data describe the write committing at this edge.
  - mem_addr and mem_wdata are 0 when neither mem_read nor mem_write is asserted.
- Halt:
  - halt asserts combinationally in the HALT cycle and stays 1 until reset.
  - While halted: imem is still driven with the frozen pc; all write strobes are 0.
- cycle_count increments every rising edge while out of reset, including while halted; wraps at 2^32.

Optional Feature:
- PROC_INSTCOUNT_EN defined:
  - Adds output inst_count[31:0], reset to 0.
  - Increments on each rising edge where (halt before the halted flag is set) or reg_write or mem_write.
  - Counts the HALT instruction exactly once.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- Reset: hold rst_n=0, then release -> pc=0, halt=0, cycle_count counts 1,2,3 on successive edges.
- Program LBI R1,5; ADDI R2,R1,-1; HALT -> trace shows reg_write R1=0x0005, then R2=0x0004; halt=1 in cycle 3; pc stays 0x0004 afterward.
- LBI R1,0x10; LBI R3,0x7F; ST R3,[R1+2]; LD R4,[R1+2] -> mem_write addr 0x0012 data 0x007F; mem_read addr 0x0012; R4=0x007F.
- BEQZ R0,+4 with R0=0 at pc 0x0000 -> next pc 0x0006. Same with R0=1 -> next pc 0x0002.
- ALU ops with R1=0x00F0, R2=0x0F0F:
  - ADD -> 0x0FFF
  - SUB (R2-R1) -> 0x0E1F
  - XOR -> 0x0FFF
  - ANDN (R1&~R2) -> 0x00F0
- Async reset mid-program: assert rst_n low between edges -> pc and halt clear immediately, without waiting for a clock edge; registers read 0.

Source files
------------

// File: rtl/proc_hier_top_if.sv
// Memory bus between the proc_hier_top core and its instruction/data memories.
// The core drives the master side; both memories are combinational on reads.
interface proc_hier_top_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output imem_addr, mem_read, mem_write, mem_addr, mem_wdata,
        input  imem_rdata, mem_rdata
    );

    modport slave (
        input  imem_addr, mem_read, mem_write, mem_addr, mem_wdata,
        output imem_rdata, mem_rdata
    );
endinterface

// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit processor core with architectural trace outputs.
// Optional macro PROC_INSTCOUNT_EN adds a retired-instruction counter output inst_count.
module proc_hier_top #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    proc_hier_top_if.master       mem_if,
    output logic [15:0]           pc,
    output logic [15:0]           inst,
    output logic                  reg_write,
    output logic [2:0]            write_reg,
    output logic [15:0]           write_data,
    output logic                  halt,
    output logic [31:0]           cycle_count,
`ifdef PROC_INSTCOUNT_EN
    output logic [31:0]           inst_count,
`endif
    output logic                  icache_req,
    output logic                  icache_hit,
    output logic                  dcache_req,
    output logic                  dcache_hit
);

    localparam logic [4:0] OpHalt = 5'b00000;
    localparam logic [4:0] OpNop  = 5'b00001;
    localparam logic [4:0] OpAddi = 5'b01000;
    localparam logic [4:0] OpSt   = 5'b10000;
    localparam logic [4:0] OpLd   = 5'b10001;
    localparam logic [4:0] OpLbi  = 5'b11000;
    localparam logic [4:0] OpBeqz = 5'b01100;
    localparam logic [4:0] OpJ    = 5'b00100;
    localparam logic [4:0] OpAlu  = 5'b11011;

    logic [15:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic [31:0] cycle_q;
    logic [15:0] regs_q [8];

    logic [4:0]  opcode;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm5, imm8, imm11;
    logic [15:0] rs_val, rt_val, ea, pc_inc;

    logic        rf_we, mem_rd, mem_wr, halt_exec;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    assign inst   = mem_if.imem_rdata;
    assign opcode = inst[15:11];
    assign rs     = inst[10:8];
    assign rt     = inst[7:5];
    assign rd     = inst[4:2];
    assign imm5   = {{11{inst[4]}}, inst[4:0]};
    assign imm8   = {{8{inst[7]}}, inst[7:0]};
    assign imm11  = {{5{inst[10]}}, inst[10:0]};
    assign rs_val = regs_q[rs];
    assign rt_val = regs_q[rt];
    assign ea     = rs_val + imm5;
    assign pc_inc = pc_q + 16'd2;

    always_comb begin
        pc_d      = pc_inc;
        halted_d  = halted_q;
        rf_we     = 1'b0;
        rf_waddr  = 3'd0;
        rf_wdata  = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halt_exec = 1'b0;
        if (halted_q) begin
            pc_d = pc_q;
        end else begin
            case (opcode)
                OpHalt: begin
                    halt_exec = 1'b1;
                    halted_d  = 1'b1;
                    pc_d      = pc_q;
                end
                OpNop: ;
                OpAddi: begin
                    rf_we    = 1'b1;
                    rf_waddr = rt;
                    rf_wdata = rs_val + imm5;
                end
                OpSt: mem_wr = 1'b1;
                OpLd: begin
                    mem_rd   = 1'b1;
                    rf_we    = 1'b1;
                    rf_waddr = rt;
                    rf_wdata = mem_if.mem_rdata;
                end
                OpLbi: begin
                    rf_we    = 1'b1;
                    rf_waddr = rs;
                    rf_wdata = imm8;
                end
                OpBeqz: if (rs_val == 16'h0000) pc_d = pc_inc + imm8;
                OpJ:    pc_d = pc_inc + imm11;
                OpAlu: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd;
                    case (inst[1:0])
                        2'b00:   rf_wdata = rs_val + rt_val;
                        2'b01:   rf_wdata = rt_val - rs_val;
                        2'b10:   rf_wdata = rs_val ^ rt_val;
                        default: rf_wdata = rs_val & ~rt_val;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst_n so they drop asynchronously with reset.
    assign reg_write  = rf_we & rst_n;
    assign write_reg  = rf_waddr;
    assign write_data = rf_wdata;
    assign halt       = (halted_q | halt_exec) & rst_n;

    assign mem_if.imem_addr = pc_q;
    assign mem_if.mem_read  = mem_rd & rst_n;
    assign mem_if.mem_write = mem_wr & rst_n;
    assign mem_if.mem_addr  = (mem_if.mem_read | mem_if.mem_write) ? ea : 16'h0000;
    assign mem_if.mem_wdata = mem_if.mem_write ? rt_val : 16'h0000;

    assign pc          = pc_q;
    assign cycle_count = cycle_q;
    assign icache_req  = 1'b0;
    assign icache_hit  = 1'b0;
    assign dcache_req  = 1'b0;
    assign dcache_hit  = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            cycle_q  <= 32'd0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cycle_q  <= cycle_q + 32'd1;
            if (reg_write) regs_q[write_reg] <= write_data;
        end
    end

`ifdef PROC_INSTCOUNT_EN
    logic [31:0] inst_cnt_q;

    // halt_exec is only raised before the halted flag sets, so HALT counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inst_cnt_q <= 32'd0;
        else if (halt_exec || reg_write || mem_if.mem_write) inst_cnt_q <= inst_cnt_q + 32'd1;
    end

    assign inst_count = inst_cnt_q;
`endif

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed bench for proc_hier_top: per-cycle trace tables plus reset sequences.
module tb_proc_hier_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc, inst, write_data;
    logic        reg_write, halt;
    logic [2:0]  write_reg;
    logic [31:0] cycle_count;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
`ifdef PROC_INSTCOUNT_EN
    logic [31:0] inst_count;
`endif

    proc_hier_top_if bus ();

    proc_hier_top #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_if      (bus.master),
        .pc          (pc),
        .inst        (inst),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .halt        (halt),
        .cycle_count (cycle_count),
`ifdef PROC_INSTCOUNT_EN
        .inst_count  (inst_count),
`endif
        .icache_req  (icache_req),
        .icache_hit  (icache_hit),
        .dcache_req  (dcache_req),
        .dcache_hit  (dcache_hit)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [64];
    logic [15:0] dmem [256];

    assign bus.imem_rdata = imem[bus.imem_addr[6:1]];
    // Two fixed words supply ALU operands that LBI cannot build directly.
    assign bus.mem_rdata  = (bus.mem_addr == 16'h000A) ? 16'h00F0 :
                            (bus.mem_addr == 16'h000C) ? 16'h0F0F : dmem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_write) dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    typedef struct {
        logic [15:0] pc;
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic [15:0] ma;
        logic [15:0] mwd;
        logic        hlt;
    } vec_t;

    vec_t tbl [23];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [15:0] p, input logic rw, input logic [2:0] wr,
                                input logic [15:0] wd, input logic mr, input logic mw,
                                input logic [15:0] ma, input logic [15:0] mwd, input logic h);
        vec_t v;
        v.pc = p; v.rw = rw; v.wr = wr; v.wd = wd; v.mr = mr; v.mw = mw;
        v.ma = ma; v.mwd = mwd; v.hlt = h;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'h0800;
    endtask

    // Rows lo..hi are one program; the first row is sampled right after reset release.
    task automatic run_rows(input int lo, input int hi, input bit chk_cycles);
        for (int i = lo; i <= hi; i++) begin
            if (i > lo) @(negedge clk);
            #1;
            chk($sformatf("row%0d pc", i), {16'h0, pc}, {16'h0, tbl[i].pc});
            chk($sformatf("row%0d reg_write", i), {31'h0, reg_write}, {31'h0, tbl[i].rw});
            if (tbl[i].rw) begin
                chk($sformatf("row%0d write_reg", i), {29'h0, write_reg}, {29'h0, tbl[i].wr});
                chk($sformatf("row%0d write_data", i), {16'h0, write_data}, {16'h0, tbl[i].wd});
            end
            chk($sformatf("row%0d mem_read", i), {31'h0, bus.mem_read}, {31'h0, tbl[i].mr});
            chk($sformatf("row%0d mem_write", i), {31'h0, bus.mem_write}, {31'h0, tbl[i].mw});
            chk($sformatf("row%0d mem_addr", i), {16'h0, bus.mem_addr}, {16'h0, tbl[i].ma});
            chk($sformatf("row%0d mem_wdata", i), {16'h0, bus.mem_wdata}, {16'h0, tbl[i].mwd});
            chk($sformatf("row%0d halt", i), {31'h0, halt}, {31'h0, tbl[i].hlt});
            if (chk_cycles) chk($sformatf("row%0d cycle_count", i), cycle_count, 32'(i - lo));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Program 1: LBI R1,5; ADDI R2,R1,-1; HALT
        tbl[0]  = mk(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0, 16'h0, 0);
        tbl[1]  = mk(16'h0002, 1, 3'd2, 16'h0004, 0, 0, 16'h0, 16'h0, 0);
        tbl[2]  = mk(16'h0004, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        tbl[3]  = mk(16'h0004, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        // Program 2: store/load then the four ALU ops
        tbl[4]  = mk(16'h0000, 1, 3'd1, 16'h0010, 0, 0, 16'h0, 16'h0, 0);
        tbl[5]  = mk(16'h0002, 1, 3'd3, 16'h007F, 0, 0, 16'h0, 16'h0, 0);
        tbl[6]  = mk(16'h0004, 0, 3'd0, 16'h0000, 0, 1, 16'h0012, 16'h007F, 0);
        tbl[7]  = mk(16'h0006, 1, 3'd4, 16'h007F, 1, 0, 16'h0012, 16'h0, 0);
        tbl[8]  = mk(16'h0008, 1, 3'd1, 16'h00F0, 1, 0, 16'h000A, 16'h0, 0);
        tbl[9]  = mk(16'h000A, 1, 3'd2, 16'h0F0F, 1, 0, 16'h000C, 16'h0, 0);
        tbl[10] = mk(16'h000C, 1, 3'd5, 16'h0FFF, 0, 0, 16'h0, 16'h0, 0);
        tbl[11] = mk(16'h000E, 1, 3'd6, 16'h0E1F, 0, 0, 16'h0, 16'h0, 0);
        tbl[12] = mk(16'h0010, 1, 3'd7, 16'h0FFF, 0, 0, 16'h0, 16'h0, 0);
        tbl[13] = mk(16'h0012, 1, 3'd3, 16'h00F0, 0, 0, 16'h0, 16'h0, 0);
        tbl[14] = mk(16'h0014, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        tbl[15] = mk(16'h0014, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        // Program 3: BEQZ taken, LBI R0,1, BEQZ not taken, J +4, unused opcode, HALT
        tbl[16] = mk(16'h0000, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
        tbl[17] = mk(16'h0006, 1, 3'd0, 16'h0001, 0, 0, 16'h0, 16'h0, 0);
        tbl[18] = mk(16'h0008, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
        tbl[19] = mk(16'h000A, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
        tbl[20] = mk(16'h0010, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
        tbl[21] = mk(16'h0012, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);
        tbl[22] = mk(16'h0012, 0, 3'd0, 16'h0000, 0, 0, 16'h0, 16'h0, 1);

        for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;

        // Reset state, then program 1 with cycle_count tracking.
        clear_imem();
        imem[0] = 16'hC105;
        imem[1] = 16'h415F;
        imem[2] = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("reset pc", {16'h0, pc}, 32'h0);
        chk("reset halt", {31'h0, halt}, 32'h0);
        chk("reset cycle_count", cycle_count, 32'h0);
        chk("reset reg_write", {31'h0, reg_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(0, 3, 1'b1);
`ifdef PROC_INSTCOUNT_EN
        chk("inst_count prog1", inst_count, 32'd3);
`endif

        // Asynchronous reset between edges while halted with R1=5, R2=4.
        #2;
        imem[0] = 16'hD954;
        rst_n = 1'b0;
        #1;
        chk("async pc", {16'h0, pc}, 32'h0);
        chk("async halt", {31'h0, halt}, 32'h0);
        chk("async cycle_count", cycle_count, 32'h0);
        chk("async reg_write", {31'h0, reg_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset add reg_write", {31'h0, reg_write}, 32'h1);
        chk("post-reset add write_reg", {29'h0, write_reg}, 32'd5);
        chk("post-reset add data", {16'h0, write_data}, 32'h0);

        // Program 2
        rst_n = 1'b0;
        clear_imem();
        imem[0] = 16'hC110;
        imem[1] = 16'hC37F;
        imem[2] = 16'h8162;
        imem[3] = 16'h8982;
        imem[4] = 16'h882A;
        imem[5] = 16'h884C;
        imem[6] = 16'hD954;
        imem[7] = 16'hD959;
        imem[8] = 16'hD95E;
        imem[9] = 16'hD94F;
        imem[10] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(4, 15, 1'b0);

        // Program 3
        rst_n = 1'b0;
        clear_imem();
        imem[0] = 16'h6004;
        imem[3] = 16'hC001;
        imem[4] = 16'h6004;
        imem[5] = 16'h2004;
        imem[8] = 16'hF800;
        imem[9] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(16, 22, 1'b0);

        chk("cache tie-offs", {28'h0, icache_req, icache_hit, dcache_req, dcache_hit}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
